// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the milano pipeline.
// ALU results pass straight to writeback one cycle after accept. Loads and
// stores run one outstanding data-bus transaction (req/gnt, then rvalid),
// with byte-lane alignment on writes and sign/zero extension on loads.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a new EX result; ALU ops and misaligned accesses
//       | complete here in a single cycle
// REQ   | data_req_o asserted, request fields held until data_gnt_i
// WAIT  | granted, waiting for data_rvalid_i to complete the access

module mem_stage (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ex_valid_i,
    output logic        ex_ready_o,
    input  logic        rd_wr_en_i,
    input  logic [4:0]  rd_addr_i,
    input  logic [31:0] alu_result_i,
    input  logic        mem_en_i,
    input  logic        mem_we_i,
    input  logic [1:0]  mem_size_i,
    input  logic        mem_signed_i,
    input  logic [31:0] store_data_i,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i,
    input  logic        data_err_i,
    output logic        wb_valid_o,
    output logic        reg_we_o,
    output logic [4:0]  wr_addr_o,
    output logic [31:0] rd_wdata_o,
    output logic        lsu_err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Request registers, latched on accept of an aligned memory op
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic        we_q;
    logic        rd_we_q;
    logic [4:0]  rd_addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;

    // Writeback output registers
    logic        wb_valid_q;
    logic        reg_we_q;
    logic [4:0]  wr_addr_q;
    logic [31:0] rd_wdata_q;
    logic        lsu_err_q;

    logic        accept;
    logic        misaligned;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] rdata_sh;
    logic [31:0] load_data;

    assign accept = ex_valid_i && (state_q == IDLE);

    // Size 2'b11 behaves as a word everywhere, hence the test on size[1]
    assign misaligned = ((mem_size_i == 2'b01) && alu_result_i[0]) ||
                        (mem_size_i[1] && (alu_result_i[1:0] != 2'b00));

    // Byte enables and lane-replicated write data for the incoming op
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = store_data_i;
        case (mem_size_i)
            2'b00: begin
                be_d    = 4'b0001 << alu_result_i[1:0];
                wdata_d = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                be_d    = 4'b0011 << {alu_result_i[1], 1'b0};
                wdata_d = {2{store_data_i[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = store_data_i;
            end
        endcase
    end

    // Load extraction: shift the addressed lane down, then extend
    assign rdata_sh = data_rdata_i >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_data = rdata_sh;
        case (size_q)
            2'b00:   load_data = {{24{signed_q & rdata_sh[7]}},  rdata_sh[7:0]};
            2'b01:   load_data = {{16{signed_q & rdata_sh[15]}}, rdata_sh[15:0]};
            default: load_data = rdata_sh;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state logic; stray gnt/rvalid in the wrong state are ignored
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ex_valid_i && mem_en_i && !misaligned) state_d = REQ;
            REQ:     if (data_gnt_i)    state_d = WAIT;
            WAIT:    if (data_rvalid_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request registers hold the bus fields stable for the whole transaction
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q    <= '0;
            size_q    <= '0;
            signed_q  <= 1'b0;
            we_q      <= 1'b0;
            rd_we_q   <= 1'b0;
            rd_addr_q <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
        end else if (accept && mem_en_i && !misaligned) begin
            addr_q    <= alu_result_i;
            size_q    <= mem_size_i;
            signed_q  <= mem_signed_i;
            we_q      <= mem_we_i;
            rd_we_q   <= rd_wr_en_i;
            rd_addr_q <= rd_addr_i;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
        end
    end

    // Writeback register: strobes pulse for one cycle, addr/data hold
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_valid_q <= 1'b0;
            reg_we_q   <= 1'b0;
            wr_addr_q  <= '0;
            rd_wdata_q <= '0;
            lsu_err_q  <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            reg_we_q   <= 1'b0;
            lsu_err_q  <= 1'b0;
            if (accept && !mem_en_i) begin
                wb_valid_q <= 1'b1;
                reg_we_q   <= rd_wr_en_i;
                wr_addr_q  <= rd_addr_i;
                rd_wdata_q <= alu_result_i;
            end else if (accept && misaligned) begin
                wb_valid_q <= 1'b1;
                wr_addr_q  <= rd_addr_i;
                lsu_err_q  <= 1'b1;
            end else if ((state_q == WAIT) && data_rvalid_i) begin
                wb_valid_q <= 1'b1;
                reg_we_q   <= !we_q && rd_we_q && !data_err_i;
                wr_addr_q  <= rd_addr_q;
                lsu_err_q  <= data_err_i;
                if (!we_q) rd_wdata_q <= load_data;
            end
        end
    end

    assign ex_ready_o   = (state_q == IDLE);
    assign data_req_o   = (state_q == REQ);
    assign data_addr_o  = {addr_q[31:2], 2'b00};
    assign data_we_o    = we_q;
    assign data_be_o    = be_q;
    assign data_wdata_o = wdata_q;

    assign wb_valid_o = wb_valid_q;
    assign reg_we_o   = reg_we_q;
    assign wr_addr_o  = wr_addr_q;
    assign rd_wdata_o = rd_wdata_q;
    assign lsu_err_o  = lsu_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed scenarios plus randomized ops checked
// against a byte-level reference model.

module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic        rd_wr_en = 1'b0;
    logic [4:0]  rd_addr = '0;
    logic [31:0] alu_result = '0;
    logic        mem_en = 1'b0;
    logic        mem_we = 1'b0;
    logic [1:0]  mem_size = '0;
    logic        mem_signed = 1'b0;
    logic [31:0] store_data = '0;
    logic        data_req;
    logic        data_gnt = 1'b0;
    logic [31:0] data_addr;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_wdata;
    logic        data_rvalid = 1'b0;
    logic [31:0] data_rdata = '0;
    logic        data_err = 1'b0;
    logic        wb_valid;
    logic        reg_we;
    logic [4:0]  wr_addr;
    logic [31:0] rd_wdata;
    logic        lsu_err;

    int checks = 0;
    int errors = 0;

    // Observations gathered by run_op
    int          obs_lat, obs_req_cycles, obs_early_wb;
    logic [31:0] obs_addr, obs_wdata, obs_wd;
    logic [3:0]  obs_be;
    logic [4:0]  obs_wa;
    logic        obs_we, obs_wb, obs_regwe, obs_err, obs_rdy_acc, obs_rdy_rv;
    logic        obs_wb_next, obs_timeout, obs_unstable;

    mem_stage dut (
        .clk_i(clk), .rst_i(rst),
        .ex_valid_i(ex_valid), .ex_ready_o(ex_ready),
        .rd_wr_en_i(rd_wr_en), .rd_addr_i(rd_addr), .alu_result_i(alu_result),
        .mem_en_i(mem_en), .mem_we_i(mem_we), .mem_size_i(mem_size),
        .mem_signed_i(mem_signed), .store_data_i(store_data),
        .data_req_o(data_req), .data_gnt_i(data_gnt), .data_addr_o(data_addr),
        .data_we_o(data_we), .data_be_o(data_be), .data_wdata_o(data_wdata),
        .data_rvalid_i(data_rvalid), .data_rdata_i(data_rdata), .data_err_i(data_err),
        .wb_valid_o(wb_valid), .reg_we_o(reg_we), .wr_addr_o(wr_addr),
        .rd_wdata_o(rd_wdata), .lsu_err_o(lsu_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic is_misaligned(input logic [31:0] a, input logic [1:0] sz);
        return (int'(a % 4) % nbytes(sz)) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [31:0] a, input logic [1:0] sz);
        logic [3:0] b = '0;
        int off = int'(a % 4);
        for (int i = 0; i < nbytes(sz); i++) b[off + i] = 1'b1;
        return b;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] sd, input logic [1:0] sz);
        logic [31:0] w = '0;
        int n = nbytes(sz);
        for (int lane = 0; lane < 4; lane++) w[8*lane +: 8] = sd[8*(lane % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] a,
                                               input logic [1:0] sz, input logic sgn);
        longint v;
        longint span;
        int n = nbytes(sz);
        span = longint'(1) << (8 * n);
        v = longint'({32'h0, rdata}) >> (8 * int'(a % 4));
        v = v % span;
        if (sgn && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one op from IDLE and plays the bus side; leaves results in obs_*.
    task automatic run_op(input logic men, input logic we, input logic [1:0] sz,
                          input logic sgn, input logic rdwe, input logic [4:0] rd,
                          input logic [31:0] a, input logic [31:0] sd,
                          input logic [31:0] rdata, input int gnt_dly, input int rv_dly,
                          input logic err, input logic noise);
        int guard = 0;
        obs_req_cycles = 0; obs_early_wb = 0; obs_timeout = 0; obs_unstable = 0;
        obs_rdy_rv = 1'b1; obs_addr = '0; obs_be = '0; obs_we = 1'b0; obs_wdata = '0;
        ex_valid = 1'b1; mem_en = men; mem_we = we; mem_size = sz; mem_signed = sgn;
        rd_wr_en = rdwe; rd_addr = rd; alu_result = a; store_data = sd;
        obs_rdy_acc = ex_ready;
        step();
        ex_valid = 1'b0;
        alu_result = $urandom; store_data = $urandom; mem_size = 2'($urandom);
        obs_lat = 1;
        if (data_req) begin
            while (data_req && guard < 50) begin
                obs_req_cycles++;
                if (obs_req_cycles == 1) begin
                    obs_addr = data_addr; obs_be = data_be; obs_we = data_we; obs_wdata = data_wdata;
                end else if (data_addr !== obs_addr || data_be !== obs_be ||
                             data_we !== obs_we || data_wdata !== obs_wdata) begin
                    obs_unstable = 1'b1;
                end
                if (wb_valid) obs_early_wb++;
                data_gnt = (obs_req_cycles > gnt_dly);
                data_rvalid = noise && !data_gnt;
                data_rdata = $urandom;
                step();
                obs_lat++; guard++;
                data_gnt = 1'b0; data_rvalid = 1'b0;
            end
            if (guard >= 50) obs_timeout = 1'b1;
            for (int k = 0; k < rv_dly; k++) begin
                if (wb_valid) obs_early_wb++;
                data_gnt = noise;
                step();
                obs_lat++;
                data_gnt = 1'b0;
            end
            data_rvalid = 1'b1; data_rdata = rdata; data_err = err;
            obs_rdy_rv = ex_ready;
            if (wb_valid) obs_early_wb++;
            step();
            obs_lat++;
            data_rvalid = 1'b0; data_err = 1'b0; data_rdata = $urandom;
        end
        obs_wb = wb_valid; obs_regwe = reg_we; obs_err = lsu_err;
        obs_wa = wr_addr; obs_wd = rd_wdata;
        step();
        obs_wb_next = wb_valid;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        checks++;
        if ({data_req, data_we, data_be, data_addr, data_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_bus: got req=%b we=%b be=%b addr=%h wdata=%h, want all zero",
                     data_req, data_we, data_be, data_addr, data_wdata);
        end
        checks++;
        if ({wb_valid, reg_we, wr_addr, rd_wdata, lsu_err} !== '0) begin
            errors++;
            $display("FAIL reset_wb: got wb=%b we=%b wa=%0d wd=%h err=%b, want all zero",
                     wb_valid, reg_we, wr_addr, rd_wdata, lsu_err);
        end
        checks++;
        if (ex_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b want 1", ex_ready);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_alu();
        logic [4:0]  exp_rd;
        logic [31:0] exp_res;
        logic        exp_we;
        run_op(1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 5'd5, 32'h1234_5678, 32'h0, 32'h0, 0, 0, 1'b0, 1'b0);
        checks++;
        if ({obs_wb, obs_regwe, obs_wa, obs_wd, obs_err} !== {1'b1, 1'b1, 5'd5, 32'h1234_5678, 1'b0}) begin
            errors++;
            $display("FAIL alu_basic: got wb=%b we=%b wa=%0d wd=%h err=%b, want 1 1 5 12345678 0",
                     obs_wb, obs_regwe, obs_wa, obs_wd, obs_err);
        end
        checks++;
        if (obs_lat != 1 || obs_req_cycles != 0 || obs_wb_next !== 1'b0) begin
            errors++;
            $display("FAIL alu_timing: got lat=%0d req=%0d wb_next=%b, want 1 0 0",
                     obs_lat, obs_req_cycles, obs_wb_next);
        end
        // back-to-back ALU ops, one per cycle
        mem_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ex_valid = 1'b1;
            exp_rd = 5'($urandom); exp_res = $urandom; exp_we = 1'($urandom);
            rd_addr = exp_rd; alu_result = exp_res; rd_wr_en = exp_we;
            checks++;
            if (ex_ready !== 1'b1) begin
                errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, ex_ready);
            end
            step();
            checks++;
            if ({wb_valid, reg_we, wr_addr, rd_wdata} !== {1'b1, exp_we, exp_rd, exp_res}) begin
                errors++;
                $display("FAIL b2b_wb[%0d]: got wb=%b we=%b wa=%0d wd=%h, want 1 %b %0d %h",
                         i, wb_valid, reg_we, wr_addr, rd_wdata, exp_we, exp_rd, exp_res);
            end
        end
        ex_valid = 1'b0;
        step();
        checks++;
        if (wb_valid !== 1'b0 || wr_addr !== exp_rd || rd_wdata !== exp_res) begin
            errors++;
            $display("FAIL b2b_hold: got wb=%b wa=%0d wd=%h, want 0 %0d %h",
                     wb_valid, wr_addr, rd_wdata, exp_rd, exp_res);
        end
    endtask

    task automatic test_load_byte();
        for (int u = 0; u < 2; u++) begin
            logic [31:0] want = (u == 0) ? 32'hFFFF_FF80 : 32'h0000_0080;
            run_op(1'b1, 1'b0, 2'b00, (u == 0), 1'b1, 5'd9, 32'h0000_1003, 32'h0,
                   32'h80AA_BBCC, 2, 0, 1'b0, 1'b1);
            checks++;
            if (obs_addr !== 32'h0000_1000 || obs_be !== 4'b1000 || obs_we !== 1'b0) begin
                errors++;
                $display("FAIL lb_bus[%0d]: got addr=%h be=%b we=%b, want 00001000 1000 0",
                         u, obs_addr, obs_be, obs_we);
            end
            checks++;
            if (obs_req_cycles != 3 || obs_lat != 5 || obs_timeout || obs_unstable) begin
                errors++;
                $display("FAIL lb_timing[%0d]: got req=%0d lat=%0d to=%b unst=%b, want 3 5 0 0",
                         u, obs_req_cycles, obs_lat, obs_timeout, obs_unstable);
            end
            checks++;
            if ({obs_wb, obs_regwe, obs_wa, obs_wd, obs_err} !== {1'b1, 1'b1, 5'd9, want, 1'b0}) begin
                errors++;
                $display("FAIL lb_wb[%0d]: got wb=%b we=%b wa=%0d wd=%h err=%b, want 1 1 9 %h 0",
                         u, obs_wb, obs_regwe, obs_wa, obs_wd, obs_err, want);
            end
        end
    endtask

    task automatic test_store_half();
        run_op(1'b1, 1'b1, 2'b01, 1'b0, 1'b1, 5'd3, 32'h0000_2002, 32'h0000_BEEF,
               32'hDEAD_0000, 0, 0, 1'b0, 1'b0);
        checks++;
        if ({obs_addr, obs_be, obs_wdata, obs_we} !== {32'h0000_2000, 4'b1100, 32'hBEEF_BEEF, 1'b1}) begin
            errors++;
            $display("FAIL sh_bus: got addr=%h be=%b wdata=%h we=%b, want 00002000 1100 beefbeef 1",
                     obs_addr, obs_be, obs_wdata, obs_we);
        end
        checks++;
        if ({obs_wb, obs_regwe, obs_err} !== 3'b100 || obs_lat != 3) begin
            errors++;
            $display("FAIL sh_wb: got wb=%b we=%b err=%b lat=%0d, want 1 0 0 3",
                     obs_wb, obs_regwe, obs_err, obs_lat);
        end
    endtask

    task automatic test_misaligned();
        run_op(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 5'd7, 32'h0000_3001, 32'h0, 32'h0, 0, 0, 1'b0, 1'b0);
        checks++;
        if (obs_req_cycles != 0 || obs_lat != 1 || {obs_wb, obs_err, obs_regwe} !== 3'b110) begin
            errors++;
            $display("FAIL misaligned: got req=%0d lat=%0d wb=%b err=%b we=%b, want 0 1 1 1 0",
                     obs_req_cycles, obs_lat, obs_wb, obs_err, obs_regwe);
        end
        checks++;
        if (obs_wb_next !== 1'b0 || data_req !== 1'b0) begin
            errors++;
            $display("FAIL misaligned_pulse: got wb_next=%b req=%b, want 0 0", obs_wb_next, data_req);
        end
    endtask

    task automatic test_bus_err();
        run_op(1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 5'd12, 32'h0000_4008, 32'h0,
               32'h1111_2222, 0, 1, 1'b1, 1'b0);
        checks++;
        if ({obs_wb, obs_err, obs_regwe} !== 3'b110 || obs_lat != 4) begin
            errors++;
            $display("FAIL buserr_wb: got wb=%b err=%b we=%b lat=%0d, want 1 1 0 4",
                     obs_wb, obs_err, obs_regwe, obs_lat);
        end
        checks++;
        if (obs_rdy_acc !== 1'b1 || obs_rdy_rv !== 1'b0 || ex_ready !== 1'b1) begin
            errors++;
            $display("FAIL buserr_ready: got acc=%b rv=%b after=%b, want 1 0 1",
                     obs_rdy_acc, obs_rdy_rv, ex_ready);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 60; it++) begin
            logic        men  = ($urandom_range(3) != 0);
            logic        we   = 1'($urandom);
            logic [1:0]  sz   = 2'($urandom);
            logic        sgn  = 1'($urandom);
            logic        rdwe = 1'($urandom);
            logic [4:0]  rd   = 5'($urandom);
            logic [31:0] a    = $urandom;
            logic [31:0] sd   = $urandom;
            logic [31:0] rdat = $urandom;
            int          gd   = $urandom_range(3);
            int          rv   = $urandom_range(3);
            logic        err  = ($urandom_range(4) == 0);
            logic        mis;
            if ($urandom_range(3) != 0) a = a - (a % nbytes(sz));
            mis = men && is_misaligned(a, sz);
            run_op(men, we, sz, sgn, rdwe, rd, a, sd, rdat, gd, rv, err, 1'($urandom));
            checks++;
            if (obs_wb !== 1'b1 || obs_wb_next !== 1'b0 || obs_early_wb != 0 || obs_rdy_acc !== 1'b1) begin
                errors++;
                $display("FAIL rnd_strobe[%0d]: got wb=%b next=%b early=%0d rdy=%b, want 1 0 0 1",
                         it, obs_wb, obs_wb_next, obs_early_wb, obs_rdy_acc);
            end
            if (!men) begin
                checks++;
                if ({obs_regwe, obs_wa, obs_wd, obs_err} !== {rdwe, rd, a, 1'b0} ||
                    obs_lat != 1 || obs_req_cycles != 0) begin
                    errors++;
                    $display("FAIL rnd_alu[%0d]: got we=%b wa=%0d wd=%h err=%b lat=%0d, want %b %0d %h 0 1",
                             it, obs_regwe, obs_wa, obs_wd, obs_err, obs_lat, rdwe, rd, a);
                end
            end else if (mis) begin
                checks++;
                if ({obs_regwe, obs_err} !== 2'b01 || obs_lat != 1 || obs_req_cycles != 0) begin
                    errors++;
                    $display("FAIL rnd_mis[%0d]: got we=%b err=%b lat=%0d req=%0d, want 0 1 1 0",
                             it, obs_regwe, obs_err, obs_lat, obs_req_cycles);
                end
            end else begin
                logic exp_we = !we && rdwe && !err;
                checks++;
                if (obs_addr !== {a[31:2], 2'b00} || obs_be !== model_be(a, sz) || obs_we !== we ||
                    (we && obs_wdata !== model_wdata(sd, sz)) || obs_unstable) begin
                    errors++;
                    $display("FAIL rnd_bus[%0d]: got addr=%h be=%b we=%b wdata=%h unst=%b, want %h %b %b %h 0",
                             it, obs_addr, obs_be, obs_we, obs_wdata, obs_unstable,
                             {a[31:2], 2'b00}, model_be(a, sz), we, model_wdata(sd, sz));
                end
                checks++;
                if (obs_req_cycles != gd + 1 || obs_lat != 3 + gd + rv || obs_rdy_rv !== 1'b0 || obs_timeout) begin
                    errors++;
                    $display("FAIL rnd_timing[%0d]: got req=%0d lat=%0d rdy_rv=%b to=%b, want %0d %0d 0 0",
                             it, obs_req_cycles, obs_lat, obs_rdy_rv, obs_timeout, gd + 1, 3 + gd + rv);
                end
                checks++;
                if ({obs_regwe, obs_err, obs_wa} !== {exp_we, err, rd} ||
                    (!we && !err && obs_wd !== model_load(rdat, a, sz, sgn))) begin
                    errors++;
                    $display("FAIL rnd_wb[%0d]: got we=%b err=%b wa=%0d wd=%h, want %b %b %0d %h",
                             it, obs_regwe, obs_err, obs_wa, obs_wd, exp_we, err, rd,
                             model_load(rdat, a, sz, sgn));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        // reset while in REQ
        ex_valid = 1'b1; mem_en = 1'b1; mem_we = 1'b0; mem_size = 2'b10;
        alu_result = 32'h0000_5000; rd_addr = 5'd4; rd_wr_en = 1'b1;
        step();
        ex_valid = 1'b0;
        checks++;
        if (data_req !== 1'b1) begin
            errors++; $display("FAIL rstmid_req_pre: got %b want 1", data_req);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (data_req !== 1'b0 || ex_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_req: got req=%b ready=%b, want 0 1", data_req, ex_ready);
        end
        step();
        rst = 1'b0;
        // reset while in WAIT, then a late rvalid
        ex_valid = 1'b1;
        step();
        ex_valid = 1'b0; data_gnt = 1'b1;
        step();
        data_gnt = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (data_req !== 1'b0 || ex_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_wait: got req=%b ready=%b, want 0 1", data_req, ex_ready);
        end
        step();
        rst = 1'b0;
        data_rvalid = 1'b1; data_rdata = 32'hCAFE_F00D;
        step();
        data_rvalid = 1'b0;
        checks++;
        if (wb_valid !== 1'b0 || data_req !== 1'b0 || ex_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_late_rvalid: got wb=%b req=%b ready=%b, want 0 0 1",
                     wb_valid, data_req, ex_ready);
        end
        step();
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_late_wb: got %b want 0", wb_valid);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_byte();
        test_store_half();
        test_misaligned();
        test_bus_err();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
